regfile_wb_arbiter: RTL

Writer side of the integer register file write port (rd / rd_data / write-enable). Merges two result sources onto the single port: the fixed-latency ALU path and the long-latency load/mul-div path. The long-latency path is buffered in a small FIFO. A per-register pending scoreboard is kept for the hazard unit.

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter that merges ALU results with buffered long-latency results and keeps a pending scoreboard.
// Optional macro WB_CONTENTION_CNT_EN adds contention_cnt_o, which counts cycles where the ALU wins over a non-empty FIFO.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_i,
  input  logic [XLEN-1:0]               alu_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [4:0]                    lsu_rd_i,
  input  logic [XLEN-1:0]               lsu_data_i,
  input  logic                          issue_valid_i,
  input  logic [4:0]                    issue_rd_i,
  input  logic                          flush_i,
  output logic                          wr_reg_en_o,
  output logic [4:0]                    rd_o,
  output logic [XLEN-1:0]               rd_data_o,
  output logic [31:0]                   pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef WB_CONTENTION_CNT_EN
  ,
  output logic [31:0]                   contention_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];
  logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_wr_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic [31:0]     r_pending;

  logic            w_alu_sel;
  logic            w_fifo_empty;
  logic            w_xfer;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_clr_mask;

  // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
  assign lsu_ready_o  = (r_count < CW'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_alu_sel    = alu_valid_i && (alu_rd_i != 5'd0);
  assign w_xfer       = lsu_valid_i && lsu_ready_o && !flush_i;
  assign w_pop        = !w_alu_sel && !w_fifo_empty && !flush_i;
  assign w_bypass     = !w_alu_sel && w_fifo_empty && w_xfer && (lsu_rd_i != 5'd0);
  assign w_push       = w_xfer && (lsu_rd_i != 5'd0) && !w_bypass;
  assign w_head_rd    = r_fifo_rd[r_rptr];
  assign w_head_data  = r_fifo_data[r_rptr];

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid_i && (issue_rd_i != 5'd0))
      w_set_mask[issue_rd_i] = 1'b1;
    if (w_pop)
      w_clr_mask[w_head_rd] = 1'b1;
    if (w_bypass)
      w_clr_mask[lsu_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= lsu_data_i;
      r_fifo_rd[r_wptr]   <= lsu_rd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  // Priority is ALU, then FIFO head, then bypass; with no winner the address and data hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_alu_sel) begin
        r_wr_en <= 1'b1;
        r_rd    <= alu_rd_i;
        r_data  <= alu_data_i;
      end else if (w_pop) begin
        r_wr_en <= 1'b1;
        r_rd    <= w_head_rd;
        r_data  <= w_head_data;
      end else if (w_bypass) begin
        r_wr_en <= 1'b1;
        r_rd    <= lsu_rd_i;
        r_data  <= lsu_data_i;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_pending <= '0;
    else if (flush_i)
      r_pending <= '0;
    else
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

`ifdef WB_CONTENTION_CNT_EN
  logic [31:0] r_contention_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_contention_cnt <= '0;
    else if (w_alu_sel && !w_fifo_empty && (r_contention_cnt != '1))
      r_contention_cnt <= r_contention_cnt + 32'd1;
  end

  assign contention_cnt_o = r_contention_cnt;
`endif

  assign wr_reg_en_o  = r_wr_en;
  assign rd_o         = r_rd;
  assign rd_data_o    = r_data;
  assign pending_o    = r_pending;
  assign fifo_count_o = r_count;

endmodule
